// File: rtl/regfile_sb.sv
// Multi-read register file (x0 = 0) with per-register busy scoreboard and sequential clear engine.
// Reads are combinational; writes and scoreboard updates land on the next edge; clear takes DEPTH-1 cycles.
// No backpressure: writes/sets during a clear are dropped and the pipeline must stall on clr_busy. Option: RF_BYPASS_EN.
module regfile_sb #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_READ = 2,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
    output logic [NUM_READ*WIDTH-1:0]    rd_data,
    output logic [NUM_READ-1:0]          rd_busy,
    input  logic                         sb_set_en,
    input  logic [ADDR_W-1:0]            sb_set_addr,
    input  logic                         clr_req,
    output logic                         clr_busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  clr_cnt;
    logic [ADDR_W-1:0]  clr_cnt_nxt;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]   busy;
    logic [DEPTH-1:0]   busy_nxt;

    logic               wr_ok;
    logic               set_ok;
    logic [ADDR_W-1:0]  ra [NUM_READ];

    // Writeback and issue are only honoured while idle; during a clear they are dropped.
    assign wr_ok    = wr_en     && (wr_addr     != '0) && (state == S_IDLE);
    assign set_ok   = sb_set_en && (sb_set_addr != '0) && (state == S_IDLE);
    assign clr_busy = (state == S_CLEAR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            S_IDLE: begin
                if (clr_req) begin
                    state_nxt   = S_CLEAR;
                    clr_cnt_nxt = ADDR_W'(1);
                end
            end
            S_CLEAR: begin
                if (clr_cnt == LAST_IDX) begin
                    state_nxt   = S_IDLE;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                end
            end
            default: begin
                state_nxt   = S_IDLE;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    // mem[0] is never written: writes to 0 are gated and the clear sweep starts at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == S_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A set issued in the same cycle as a writeback to the same register wins.
    always_comb begin
        busy_nxt = busy;
        if (state == S_CLEAR) begin
            busy_nxt[clr_cnt] = 1'b0;
        end else begin
            if (wr_ok) begin
                busy_nxt[wr_addr] = 1'b0;
            end
            if (set_ok) begin
                busy_nxt[sb_set_addr] = 1'b1;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    for (genvar g = 0; g < NUM_READ; g++) begin : g_ra
        assign ra[g] = rd_addr[g*ADDR_W +: ADDR_W];
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            if (ra[i] != '0) begin
                rd_data[i*WIDTH +: WIDTH] = mem[ra[i]];
                rd_busy[i]                = busy[ra[i]];
`ifdef RF_BYPASS_EN
                // Forwarded value is not yet busy even if re-issued this cycle; the set lands next edge.
                if (wr_ok && (ra[i] == wr_addr)) begin
                    rd_data[i*WIDTH +: WIDTH] = wr_data;
                    rd_busy[i]                = 1'b0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed stimulus for regfile_sb; expected read data/busy/clr_busy come from a plain array model.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        sb_set_en;
    logic [4:0]  sb_set_addr;
    logic        clr_req;
    logic        clr_busy;

    regfile_sb #(.WIDTH(32), .DEPTH(32), .NUM_READ(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .clr_req     (clr_req),
        .clr_busy    (clr_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  busy;
        logic        cb;
    } exp_t;

    exp_t        q[$];
    int          n_chk   = 0;
    int          n_pass  = 0;
    int          cb_cnt  = 0;

    // Reference state: register values, busy flags, and how far a clear sweep has progressed.
    logic [31:0] m_reg  [32];
    logic        m_busy [32];
    bit          m_clr;
    int          m_ptr;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_clr = 1'b0;
        m_ptr = 0;
    endfunction

    function automatic void model_edge(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                       input logic ss, input logic [4:0] sa, input logic cr);
        if (m_clr) begin
            m_reg[m_ptr]  = '0;
            m_busy[m_ptr] = 1'b0;
            m_ptr++;
            if (m_ptr == 32) m_clr = 1'b0;
        end else begin
            if (we && wa != 0) begin
                m_reg[wa]  = wd;
                m_busy[wa] = 1'b0;
            end
            if (ss && sa != 0) m_busy[sa] = 1'b1;
            if (cr) begin
                m_clr = 1'b1;
                m_ptr = 1;
            end
        end
    endfunction

    task automatic step(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic ss, input logic [4:0] sa, input logic cr,
                        input logic [4:0] a0, input logic [4:0] a1);
        exp_t        e;
        logic [4:0]  a;
        logic [31:0] d;
        logic        b;
        @(negedge clk);
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
        sb_set_en = ss; sb_set_addr = sa; clr_req = cr;
        rd_addr = {a1, a0};
        if (r) model_reset();
        e.cb = m_clr;
        for (int p = 0; p < 2; p++) begin
            a = (p == 0) ? a0 : a1;
            d = (a == 0) ? 32'h0 : m_reg[a];
            b = (a == 0) ? 1'b0  : m_busy[a];
`ifdef RF_BYPASS_EN
            if (!r && !m_clr && we && wa != 0 && a == wa) begin
                d = wd;
                b = 1'b0;
            end
`endif
            e.data[p*32 +: 32] = d;
            e.busy[p]          = b;
        end
        q.push_back(e);
        @(posedge clk);
        if (!r) model_edge(we, wa, wd, ss, sa, cr);
    endtask

    task automatic idle(input logic [4:0] a0, input logic [4:0] a1);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, a0, a1);
    endtask

    // Monitor: outputs are always presented; sample each cycle away from the edge and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (clr_busy === 1'b1) cb_cnt++;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rd_data0", rd_data[31:0],  e.data[31:0]);
                chk("rd_data1", rd_data[63:32], e.data[63:32]);
                chk("rd_busy0", 32'(rd_busy[0]), 32'(e.busy[0]));
                chk("rd_busy1", 32'(rd_busy[1]), 32'(e.busy[1]));
                chk("clr_busy", 32'(clr_busy),   32'(e.cb));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation bound expired");
        $fatal(1);
    end

    initial begin
        logic        r, we, ss, cr;
        logic [4:0]  wa, sa, a0, a1;
        logic [31:0] wd;

        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        sb_set_en = 1'b0; sb_set_addr = '0; clr_req = 1'b0; rd_addr = '0;
        model_reset();

        // Reset, then read x5/x31.
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd31);
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd31);
        idle(5'd5, 5'd31);

        // Write x7, attempted write x0, read both.
        step(1'b0, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0);
        step(1'b0, 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0);
        idle(5'd7, 5'd0);

        // Scoreboard set, clearing writeback, then simultaneous set+write.
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd0);
        idle(5'd3, 5'd0);
        idle(5'd3, 5'd0);
        idle(5'd3, 5'd0);
        step(1'b0, 1'b1, 5'd3, 32'hA5, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0);
        idle(5'd3, 5'd0);
        step(1'b0, 1'b1, 5'd3, 32'h5A, 1'b1, 5'd3, 1'b0, 5'd3, 5'd0);
        idle(5'd3, 5'd0);

        // Fill, clear, dropped write of x9 mid-clear, count clr_busy cycles.
        for (int i = 1; i < 32; i++)
            step(1'b0, 1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 1'b0, 5'(i), 5'd0);
        cb_cnt = 0;
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd1, 5'd31);
        for (int i = 0; i < 35; i++) begin
            if (i == 4) step(1'b0, 1'b1, 5'd9, 32'hFF, 1'b1, 5'd9, 1'b1, 5'd9, 5'd31);
            else        idle(5'd9, 5'(i));
        end
        chk("clr_busy_cycles", 32'(cb_cnt), 32'd31);
        for (int i = 0; i < 16; i++) idle(5'(i), 5'(i + 16));

        // Reset 10 cycles into a clear, then a new clear is accepted.
        for (int i = 1; i < 32; i += 3)
            step(1'b0, 1'b1, 5'(i), 32'hC0DE0000 | 32'(i), 1'b1, 5'(i), 1'b0, 5'(i), 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd1, 5'd28);
        for (int i = 0; i < 10; i++) idle(5'd1, 5'd28);
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd28, 5'd31);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd28, 5'd31);
        for (int i = 0; i < 33; i++) idle(5'd28, 5'd31);

        // Write x4 while reading it; forwarding decides the same-cycle value.
        step(1'b0, 1'b1, 5'd4, 32'h55, 1'b0, 5'd0, 1'b0, 5'd4, 5'd4);
        idle(5'd4, 5'd0);
        step(1'b0, 1'b1, 5'd4, 32'h66, 1'b1, 5'd4, 1'b0, 5'd4, 5'd0);
        idle(5'd4, 5'd0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom % 300) == 0;
            we = ($urandom % 2) == 0;
            wa = 5'($urandom);
            wd = $urandom;
            ss = ($urandom % 3) == 0;
            sa = (($urandom % 3) == 0) ? wa : 5'($urandom);
            cr = ($urandom % 90) == 0;
            a0 = (($urandom % 4) == 0) ? wa : 5'($urandom);
            a1 = (($urandom % 4) == 0) ? sa : 5'($urandom);
            step(r, we, wa, wd, ss, sa, cr, a0, a1);
        end

        @(negedge clk);
        #4;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
